// File: rtl/rec_play_ctrl_if.sv
// Codec-side sample handshake for rec_play_ctrl: ADC samples in, DAC samples out.
interface rec_play_ctrl_if;
  localparam int unsigned SAMPLE_W = 16;

  logic [SAMPLE_W-1:0] adc_data;
  logic                adc_vld;
  logic                dac_req;
  logic [SAMPLE_W-1:0] dac_data;
  logic                dac_vld;

  modport master (output adc_data, adc_vld, dac_req, input dac_data, dac_vld);
  modport slave  (input adc_data, adc_vld, dac_req, output dac_data, dac_vld);
endinterface

// File: rtl/rec_play_ctrl.sv
// Record/playback sequencer between a codec and an SRAM interface stage.
// Macro REC_PLAY_LOOP_EN: playback wraps to address 0 and repeats until stop.
module rec_play_ctrl #(
  parameter int unsigned ACC_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_rec,
  input  logic             start_play,
  input  logic             stop,
  rec_play_ctrl_if.slave   codec,
  output logic [17:0]      addr,
  output logic             read,
  output logic             write,
  output logic             play,
  output logic             record,
  inout  wire  [15:0]      data,
  output logic [17:0]      rec_len,
  output logic             full,
  output logic             overrun,
  output logic             done
);

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] REC_WAIT  = 3'd1;
  localparam logic [2:0] REC_WR    = 3'd2;
  localparam logic [2:0] PLAY_WAIT = 3'd3;
  localparam logic [2:0] PLAY_RD   = 3'd4;

  localparam logic [AW-1:0] ADDR_MAX = '1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACC_CYC - 1);

  logic [2:0]    state,    state_d;
  logic [CW-1:0] cnt,      cnt_d;
  logic [DW-1:0] sample,   sample_d;
  logic [AW-1:0] addr_d,   rec_len_d;
  logic [DW-1:0] dac_data_d;
  logic          read_d, write_d, play_d, record_d;
  logic          dac_vld_d, full_d, overrun_d, done_d;
  logic [AW-1:0] addr_inc;

  assign addr_inc = addr + AW'(1);

  // The latched sample owns the bus only while a recording session is open.
  assign data = record ? sample : {DW{1'bz}};

  // State and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      sample         <= '0;
      addr           <= '0;
      rec_len        <= '0;
      read           <= 1'b0;
      write          <= 1'b0;
      play           <= 1'b0;
      record         <= 1'b0;
      full           <= 1'b0;
      overrun        <= 1'b0;
      done           <= 1'b0;
      codec.dac_data <= '0;
      codec.dac_vld  <= 1'b0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      sample         <= sample_d;
      addr           <= addr_d;
      rec_len        <= rec_len_d;
      read           <= read_d;
      write          <= write_d;
      play           <= play_d;
      record         <= record_d;
      full           <= full_d;
      overrun        <= overrun_d;
      done           <= done_d;
      codec.dac_data <= dac_data_d;
      codec.dac_vld  <= dac_vld_d;
    end
  end

  // Next-state and next-output decode; strobes default low, status holds.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    sample_d   = sample;
    addr_d     = addr;
    rec_len_d  = rec_len;
    read_d     = 1'b0;
    write_d    = 1'b0;
    play_d     = play;
    record_d   = record;
    full_d     = full;
    overrun_d  = overrun;
    done_d     = 1'b0;
    dac_data_d = codec.dac_data;
    dac_vld_d  = 1'b0;

    if (stop) begin
      // Abort: an unfinished write is simply not counted.
      state_d  = IDLE;
      cnt_d    = '0;
      play_d   = 1'b0;
      record_d = 1'b0;
      done_d   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start_rec) begin
            addr_d    = '0;
            rec_len_d = '0;
            record_d  = 1'b1;
            full_d    = 1'b0;
            overrun_d = 1'b0;
            state_d   = REC_WAIT;
          end else if (start_play && (rec_len != '0)) begin
            addr_d  = '0;
            play_d  = 1'b1;
            state_d = PLAY_WAIT;
          end
        end
        REC_WAIT: begin
          if (codec.adc_vld) begin
            sample_d = codec.adc_data;
            write_d  = 1'b1;
            cnt_d    = '0;
            state_d  = REC_WR;
          end
        end
        REC_WR: begin
          if (codec.adc_vld) overrun_d = 1'b1;
          if (cnt == CNT_LAST) begin
            if (rec_len != ADDR_MAX) rec_len_d = rec_len + AW'(1);
            if (addr == ADDR_MAX) begin
              full_d   = 1'b1;
              done_d   = 1'b1;
              record_d = 1'b0;
              state_d  = IDLE;
            end else begin
              addr_d  = addr_inc;
              state_d = REC_WAIT;
            end
          end else begin
            write_d = 1'b1;
            cnt_d   = cnt + CW'(1);
          end
        end
        PLAY_WAIT: begin
          if (codec.dac_req) begin
            read_d  = 1'b1;
            cnt_d   = '0;
            state_d = PLAY_RD;
          end
        end
        PLAY_RD: begin
          if (cnt == CNT_LAST) begin
            dac_data_d = data;
            dac_vld_d  = 1'b1;
            if (addr_inc == rec_len) begin
`ifdef REC_PLAY_LOOP_EN
              addr_d  = '0;
              state_d = PLAY_WAIT;
`else
              addr_d  = addr_inc;
              play_d  = 1'b0;
              done_d  = 1'b1;
              state_d = IDLE;
`endif
            end else begin
              addr_d  = addr_inc;
              state_d = PLAY_WAIT;
            end
          end else begin
            read_d = 1'b1;
            cnt_d  = cnt + CW'(1);
          end
        end
        default: begin
          state_d  = IDLE;
          play_d   = 1'b0;
          record_d = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Self-checking bench for rec_play_ctrl with an SRAM model and a sample-level reference model.
`timescale 1ns/1ps
module tb_rec_play_ctrl;
  localparam int unsigned ACC_CYC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_rec = 1'b0, start_play = 1'b0, stop = 1'b0;
  logic [17:0] addr, rec_len;
  logic        read, write, play, record, full, overrun, done;
  wire  [15:0] data;

  rec_play_ctrl_if cif();

  rec_play_ctrl #(.ACC_CYC(ACC_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .start_rec(start_rec), .start_play(start_play),
    .stop(stop), .codec(cif), .addr(addr), .read(read), .write(write),
    .play(play), .record(record), .data(data), .rec_len(rec_len),
    .full(full), .overrun(overrun), .done(done)
  );

  always #5 clk = ~clk;

  // SRAM model: low address bits index a small array, driven onto the bus while read is high.
  logic [15:0] mem [1024];
  assign data = read ? mem[addr[9:0]] : 16'hzzzz;

  typedef struct { logic [17:0] a; logic [15:0] d; int len; } wr_t;
  wr_t wr_log[$];
  wr_t cur;
  int  wr_len = 0;
  int  rw_both = 0;
  int  done_cnt = 0;
  int  n_tests = 0;
  int  n_fail = 0;

  // Bus monitor: captures write pulses, stores written data, counts done cycles.
  always @(negedge clk) begin
    if (read && write) rw_both++;
    if (write) begin
      if (wr_len == 0) begin cur.a = addr; cur.d = data; end
      mem[addr[9:0]] = data;
      wr_len++;
    end else if (wr_len != 0) begin
      cur.len = wr_len;
      wr_log.push_back(cur);
      wr_len = 0;
    end
    if (done) done_cnt++;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rec();
    start_rec = 1'b1; @(negedge clk); start_rec = 1'b0;
  endtask

  task automatic pulse_play();
    start_play = 1'b1; @(negedge clk); start_play = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; @(negedge clk); stop = 1'b0;
  endtask

  task automatic adc(input logic [15:0] v);
    cif.adc_data = v; cif.adc_vld = 1'b1; @(negedge clk); cif.adc_vld = 1'b0;
  endtask

  task automatic dac_pulse();
    cif.dac_req = 1'b1; @(negedge clk); cif.dac_req = 1'b0;
  endtask

  // Bounded wait for dac_vld; leaves the caller on the negedge where it was seen.
  task automatic wait_vld(output logic seen);
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      if (cif.dac_vld) seen = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if ({read, write, play, record, full, overrun, done, cif.dac_vld} !== 8'h00) begin
      n_fail++; $display("FAIL reset_flags got %b want 00000000",
                         {read, write, play, record, full, overrun, done, cif.dac_vld});
    end
    n_tests++;
    if (addr !== 18'h0 || rec_len !== 18'h0) begin
      n_fail++; $display("FAIL reset_counters got addr=%h rec_len=%h want 0/0", addr, rec_len);
    end
    n_tests++;
    if (cif.dac_data !== 16'h0) begin
      n_fail++; $display("FAIL reset_dac_data got %h want 0000", cif.dac_data);
    end
    n_tests++;
    if (!(data === 16'hzzzz || data === 16'h0000)) begin
      n_fail++; $display("FAIL reset_bus got %h want zzzz", data);
    end
  endtask

  task automatic test_record_basic();
    logic [15:0] vals [3];
    int w0;
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
    w0 = wr_log.size();
    pulse_rec();
    n_tests++;
    if (record !== 1'b1 || write !== 1'b0) begin
      n_fail++; $display("FAIL rec_enter got record=%b write=%b want 1/0", record, write);
    end
    for (int i = 0; i < 3; i++) begin
      adc(vals[i]);
      cycles(4);
    end
    cycles(2);
    n_tests++;
    if (wr_log.size() - w0 != 3) begin
      n_fail++; $display("FAIL rec_pulse_count got %0d want 3", wr_log.size() - w0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (wr_log[w0+i].a !== 18'(i) || wr_log[w0+i].d !== vals[i] ||
            wr_log[w0+i].len != int'(ACC_CYC)) begin
          n_fail++; $display("FAIL rec_pulse%0d got a=%h d=%h len=%0d want a=%h d=%h len=%0d",
                             i, wr_log[w0+i].a, wr_log[w0+i].d, wr_log[w0+i].len,
                             18'(i), vals[i], ACC_CYC);
        end
      end
    end
    n_tests++;
    if (rec_len !== 18'd3 || overrun !== 1'b0 || addr !== 18'd3) begin
      n_fail++; $display("FAIL rec_len got rec_len=%0d ovr=%b addr=%0d want 3/0/3",
                         rec_len, overrun, addr);
    end
  endtask

  task automatic test_playback();
    logic [15:0] vals [3];
    logic seen;
    int d0;
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
    d0 = done_cnt;
    pulse_stop();
    cycles(1);
    n_tests++;
    if (done_cnt - d0 != 1 || record !== 1'b0 || rec_len !== 18'd3) begin
      n_fail++; $display("FAIL stop_idle got done_cycles=%0d record=%b rec_len=%0d want 1/0/3",
                         done_cnt - d0, record, rec_len);
    end
    pulse_play();
    n_tests++;
    if (play !== 1'b1) begin
      n_fail++; $display("FAIL play_enter got play=%b want 1", play);
    end
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) begin
      dac_pulse();
      wait_vld(seen);
      n_tests++;
      if (!seen || cif.dac_data !== vals[i]) begin
        n_fail++; $display("FAIL play_sample%0d got seen=%b data=%h want 1/%h",
                           i, seen, cif.dac_data, vals[i]);
      end
      cycles(2);
    end
`ifdef REC_PLAY_LOOP_EN
    dac_pulse();
    wait_vld(seen);
    n_tests++;
    if (!seen || cif.dac_data !== 16'h1111 || play !== 1'b1 || done_cnt != d0) begin
      n_fail++; $display("FAIL play_loop got seen=%b data=%h play=%b done_cycles=%0d want 1/1111/1/0",
                         seen, cif.dac_data, play, done_cnt - d0);
    end
    pulse_stop();
`else
    n_tests++;
    if (done_cnt - d0 != 1 || play !== 1'b0) begin
      n_fail++; $display("FAIL play_end got done_cycles=%0d play=%b want 1/0", done_cnt - d0, play);
    end
    dac_pulse();
    wait_vld(seen);
    n_tests++;
    if (seen || read !== 1'b0) begin
      n_fail++; $display("FAIL play_past_end got dac_vld=%b read=%b want 0/0", seen, read);
    end
`endif
    cycles(2);
  endtask

  task automatic test_overrun();
    int w0;
    w0 = wr_log.size();
    pulse_rec();
    adc(16'hAAAA);
    adc(16'hBBBB);
    cycles(5);
    n_tests++;
    if (overrun !== 1'b1 || rec_len !== 18'd1) begin
      n_fail++; $display("FAIL overrun got ovr=%b rec_len=%0d want 1/1", overrun, rec_len);
    end
    n_tests++;
    if (wr_log.size() - w0 != 1 || wr_log[wr_log.size()-1].d !== 16'hAAAA) begin
      n_fail++; $display("FAIL overrun_write got writes=%0d want 1 of AAAA", wr_log.size() - w0);
    end
    pulse_stop();
    cycles(2);
  endtask

  // Random strobe spacing: a strobe is accepted only if more than ACC_CYC cycles after the last accepted one.
  task automatic test_random();
    logic [15:0] exp_q[$];
    logic [15:0] v;
    logic        exp_ovr;
    logic        seen;
    int t, last, gap, w0, d0;
    exp_ovr = 1'b0; t = 0; last = -100;
    w0 = wr_log.size();
    pulse_rec();
    for (int i = 0; i < 14; i++) begin
      gap = int'($urandom_range(1, 5));
      v = 16'($urandom);
      if (t - last > int'(ACC_CYC)) begin exp_q.push_back(v); last = t; end
      else exp_ovr = 1'b1;
      adc(v);
      cycles(gap - 1);
      t += gap;
    end
    cycles(ACC_CYC + 2);
    n_tests++;
    if (rec_len !== 18'(exp_q.size()) || overrun !== exp_ovr) begin
      n_fail++; $display("FAIL rand_rec got rec_len=%0d ovr=%b want %0d/%b",
                         rec_len, overrun, exp_q.size(), exp_ovr);
    end
    for (int i = 0; i < exp_q.size() && w0 + i < wr_log.size(); i++) begin
      n_tests++;
      if (wr_log[w0+i].a !== 18'(i) || wr_log[w0+i].d !== exp_q[i]) begin
        n_fail++; $display("FAIL rand_write%0d got a=%h d=%h want a=%h d=%h",
                           i, wr_log[w0+i].a, wr_log[w0+i].d, 18'(i), exp_q[i]);
      end
    end
    pulse_stop();
    pulse_play();
    d0 = done_cnt;
    for (int i = 0; i < exp_q.size(); i++) begin
      dac_pulse();
      wait_vld(seen);
      n_tests++;
      if (!seen || cif.dac_data !== exp_q[i]) begin
        n_fail++; $display("FAIL rand_play%0d got seen=%b data=%h want 1/%h",
                           i, seen, cif.dac_data, exp_q[i]);
      end
      cycles(int'($urandom_range(1, 3)));
    end
`ifndef REC_PLAY_LOOP_EN
    n_tests++;
    if (done_cnt - d0 != 1 || play !== 1'b0) begin
      n_fail++; $display("FAIL rand_play_end got done_cycles=%0d play=%b want 1/0", done_cnt - d0, play);
    end
`endif
    n_tests++;
    if (rw_both != 0) begin
      n_fail++; $display("FAIL rw_exclusive got overlap_cycles=%0d want 0", rw_both);
    end
    pulse_stop();
    cycles(2);
  endtask

  task automatic test_full();
    int d0, w0;
    pulse_rec();
    cycles(1);
    force dut.addr = 18'h3FFFE;
    force dut.rec_len = 18'h3FFFE;
    @(negedge clk);
    release dut.addr;
    release dut.rec_len;
    cycles(1);
    adc(16'h5A5A);
    cycles(4);
    n_tests++;
    if (rec_len !== 18'h3FFFF || addr !== 18'h3FFFF || full !== 1'b0 || record !== 1'b1) begin
      n_fail++; $display("FAIL full_pre got rec_len=%h addr=%h full=%b record=%b want 3ffff/3ffff/0/1",
                         rec_len, addr, full, record);
    end
    d0 = done_cnt;
    adc(16'hA5A5);
    cycles(4);
    n_tests++;
    if (full !== 1'b1 || done_cnt - d0 != 1 || record !== 1'b0) begin
      n_fail++; $display("FAIL full_end got full=%b done_cycles=%0d record=%b want 1/1/0",
                         full, done_cnt - d0, record);
    end
    n_tests++;
    if (rec_len !== 18'h3FFFF || addr !== 18'h3FFFF) begin
      n_fail++; $display("FAIL full_sat got rec_len=%h addr=%h want 3ffff/3ffff", rec_len, addr);
    end
    w0 = wr_log.size();
    adc(16'h1234);
    cycles(4);
    n_tests++;
    if (wr_log.size() != w0 || write !== 1'b0) begin
      n_fail++; $display("FAIL full_idle got new_writes=%0d want 0", wr_log.size() - w0);
    end
  endtask

  task automatic test_priority_stop();
    start_rec = 1'b1; start_play = 1'b1;
    @(negedge clk);
    start_rec = 1'b0; start_play = 1'b0;
    n_tests++;
    if (record !== 1'b1 || play !== 1'b0 || full !== 1'b0) begin
      n_fail++; $display("FAIL prio got record=%b play=%b full=%b want 1/0/0", record, play, full);
    end
    adc(16'h0101); cycles(4);
    adc(16'h0202); cycles(4);
    adc(16'h0303);
    n_tests++;
    if (write !== 1'b1) begin
      n_fail++; $display("FAIL prio_wr got write=%b want 1", write);
    end
    pulse_stop();
    n_tests++;
    if (write !== 1'b0 || record !== 1'b0 || done !== 1'b1 || rec_len !== 18'd2) begin
      n_fail++; $display("FAIL stop_mid_wr got write=%b record=%b done=%b rec_len=%0d want 0/0/1/2",
                         write, record, done, rec_len);
    end
    cycles(1);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL done_width got done=%b want 0", done);
    end
    cycles(2);
  endtask

  task automatic test_async_reset();
    logic seen;
    pulse_play();
    dac_pulse();
    wait_vld(seen);
    cycles(1);
    dac_pulse();
    n_tests++;
    if (read !== 1'b1 || addr !== 18'd1) begin
      n_fail++; $display("FAIL pre_reset got read=%b addr=%0d want 1/1", read, addr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (read !== 1'b0 || play !== 1'b0 || addr !== 18'h0 || rec_len !== 18'h0) begin
      n_fail++; $display("FAIL async_reset got read=%b play=%b addr=%h rec_len=%h want 0/0/0/0",
                         read, play, addr, rec_len);
    end
    n_tests++;
    if (!(data === 16'hzzzz || data === 16'h0000) || record !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_bus got data=%h record=%b want zzzz/0", data, record);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);
    pulse_play();
    cycles(1);
    n_tests++;
    if (play !== 1'b0) begin
      n_fail++; $display("FAIL play_empty got play=%b want 0", play);
    end
  endtask

  initial begin
    cif.adc_data = 16'h0; cif.adc_vld = 1'b0; cif.dac_req = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    test_reset();
    test_record_basic();
    test_playback();
    test_overrun();
    test_random();
    test_full();
    test_priority_stop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
